// File: rtl/vendor_pkg.sv
// ---------------------------------------------------------------------------
// vendor_pkg
//   Shared definitions for the vending transaction path: coin encodings and
//   values, the goods price table, the sequencer state type and the helpers
//   that turn a one-hot coin or selection into jiao.
// ---------------------------------------------------------------------------
package vendor_pkg;

    typedef logic [2:0] coin_t;     // one-hot: 001=5, 010=10, 100=50 jiao
    typedef logic [6:0] credit_t;   // jiao, never above the credit ceiling
    typedef logic [4:0] price_t;    // jiao, largest price is 20

    localparam coin_t COIN_NONE = 3'b000;
    localparam coin_t COIN_5    = 3'b001;
    localparam coin_t COIN_10   = 3'b010;
    localparam coin_t COIN_50   = 3'b100;

    localparam credit_t VAL_5  = 7'd5;
    localparam credit_t VAL_10 = 7'd10;
    localparam credit_t VAL_50 = 7'd50;

    localparam price_t PRICE_0 = 5'd5;
    localparam price_t PRICE_1 = 5'd10;
    localparam price_t PRICE_2 = 5'd15;
    localparam price_t PRICE_3 = 5'd20;

    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, VEND, PAY, WARN} state_t;

    // Value of a one-hot coin; anything that is not a legal code is worth 0.
    function automatic credit_t coin_value(input coin_t onehot);
        case (onehot)
            COIN_5:  return VAL_5;
            COIN_10: return VAL_10;
            COIN_50: return VAL_50;
            default: return '0;
        endcase
    endfunction

    // Price of a one-hot goods selection; non-one-hot selections cost 0.
    function automatic price_t sel_price(input logic [3:0] sel);
        case (sel)
            4'b0001: return PRICE_0;
            4'b0010: return PRICE_1;
            4'b0100: return PRICE_2;
            4'b1000: return PRICE_3;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/vendor_txn_ctrl_if.sv
// ---------------------------------------------------------------------------
// vendor_txn_ctrl_if
//   Change payout handshake between the sequencer and the coin hopper.
//   change_valid  master->slave  a coin is offered on change_coin
//   change_coin   master->slave  one-hot coin being paid out
//   change_ready  slave->master  hopper takes change_coin this clk
// ---------------------------------------------------------------------------
interface vendor_txn_ctrl_if;
    import vendor_pkg::*;

    logic  change_valid;
    coin_t change_coin;
    logic  change_ready;

    modport master (output change_valid, output change_coin, input change_ready);
    modport slave  (input change_valid, input change_coin, output change_ready);

endinterface

// File: rtl/vendor_change_sel.sv
// ---------------------------------------------------------------------------
// vendor_change_sel
//   Greedy change picker: the largest coin not exceeding the remaining
//   amount (50, then 10, then 5). Returns COIN_NONE when nothing is owed.
//   remaining    in   7  amount still to pay out, jiao
//   change_coin  out  3  one-hot coin to offer next
// ---------------------------------------------------------------------------
module vendor_change_sel
    import vendor_pkg::*;
(
    input  credit_t remaining,
    output coin_t   change_coin
);

    always_comb begin
        if (remaining >= VAL_50)
            change_coin = COIN_50;
        else if (remaining >= VAL_10)
            change_coin = COIN_10;
        else if (remaining >= VAL_5)
            change_coin = COIN_5;
        else
            change_coin = COIN_NONE;
    end

endmodule

// File: rtl/vendor_txn_ctrl.sv
// ---------------------------------------------------------------------------
// vendor_txn_ctrl
//   Vending transaction sequencer: accumulates coin credit, latches the
//   selected price on confirm, checks funds, pulses dispense, then pays the
//   change one coin per handshake. Also handles cancel/refund, the COLLECT
//   inactivity timeout and the insufficient-funds warning.
//   clk, rst      clock, synchronous active-high reset
//   tick_1hz      1 Hz one-clk enable for the timeout/warning counters
//   coin_valid    one-clk strobe, coin[2:0] one-hot 5/10/50 jiao
//   sel[3:0]      one-hot goods select (5,10,15,20 jiao)
//   confirm       one-clk purchase strobe
//   cancel        one-clk refund strobe
//   chg           change payout handshake (master side)
//   credit        current credit / remaining change, jiao
//   price         latched price of the confirmed item
//   dispense      one-clk one-hot dispense pulse (latched sel)
//   coin_reject   one-clk pulse: offered coin returned
//   led_warn      active-low insufficient-funds indicator
//   busy          high in CHECK/VEND/PAY/WARN
// ---------------------------------------------------------------------------
module vendor_txn_ctrl
    import vendor_pkg::*;
#(
    parameter int TIMEOUT_SECS = 30,
    parameter int WARN_SECS    = 5,
    parameter int MAX_CREDIT   = 99
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_1hz,
    input  logic                      coin_valid,
    input  coin_t                     coin,
    input  logic [3:0]                sel,
    input  logic                      confirm,
    input  logic                      cancel,
    vendor_txn_ctrl_if.master         chg,
    output credit_t                   credit,
    output price_t                    price,
    output logic [3:0]                dispense,
    output logic                      coin_reject,
    output logic                      led_warn,
    output logic                      busy
);

    localparam int TO_W   = $clog2(TIMEOUT_SECS + 1);
    localparam int WARN_W = $clog2(WARN_SECS + 1);

    state_t            state;
    logic [TO_W-1:0]   to_cnt;
    logic [WARN_W-1:0] warn_cnt;
    logic [3:0]        sel_q;

    credit_t    coin_val;
    logic [7:0] credit_sum;   // one bit wider: 99 + 50 must not wrap
    logic       cancel_hit;
    logic       confirm_hit;
    logic       coin_take;
    credit_t    remaining;
    credit_t    pick_in;
    coin_t      pick_coin;

    // NOTE: every always_comb output gets a value on every path; a missing
    // assignment would infer a latch.
    always_comb begin
        coin_val    = coin_value(coin);
        credit_sum  = {1'b0, credit} + {1'b0, coin_val};
        cancel_hit  = (state == COLLECT) && cancel;
        confirm_hit = (state == COLLECT) && confirm && $onehot(sel);
        // A coin only lands in IDLE/COLLECT, and loses to cancel or confirm.
        coin_take   = coin_valid && $onehot(coin) && (credit_sum <= 8'(MAX_CREDIT))
                      && ((state == IDLE) || (state == COLLECT))
                      && !cancel_hit && !confirm_hit;
        remaining   = credit - {2'b00, price};
        // In VEND the first change coin is chosen from the post-purchase credit.
        pick_in     = (state == VEND) ? remaining : credit;
    end

    vendor_change_sel u_change_sel (
        .remaining   (pick_in),
        .change_coin (pick_coin)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            credit           <= '0;
            price            <= '0;
            sel_q            <= '0;
            dispense         <= '0;
            coin_reject      <= 1'b0;
            chg.change_valid <= 1'b0;
            chg.change_coin  <= COIN_NONE;
            led_warn         <= 1'b1;
            busy             <= 1'b0;
            to_cnt           <= '0;
            warn_cnt         <= '0;
        end else begin
            dispense    <= '0;
            coin_reject <= coin_valid && !coin_take;

            case (state)
                IDLE: begin
                    if (coin_take) begin
                        credit <= credit_sum[6:0];
                        to_cnt <= '0;
                        state  <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (cancel_hit) begin
                        state            <= PAY;
                        busy             <= 1'b1;
                        to_cnt           <= '0;
                        chg.change_valid <= (credit != '0);
                        chg.change_coin  <= pick_coin;
                    end else if (confirm_hit) begin
                        price  <= sel_price(sel);
                        sel_q  <= sel;
                        state  <= CHECK;
                        busy   <= 1'b1;
                        to_cnt <= '0;
                    end else if (coin_take) begin
                        credit <= credit_sum[6:0];
                        to_cnt <= '0;
                    end else if (tick_1hz) begin
                        if (to_cnt == TO_W'(TIMEOUT_SECS - 1)) begin
                            state            <= PAY;
                            busy             <= 1'b1;
                            to_cnt           <= '0;
                            chg.change_valid <= (credit != '0);
                            chg.change_coin  <= pick_coin;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end

                CHECK: begin
                    if (credit >= {2'b00, price}) begin
                        state    <= VEND;
                        dispense <= sel_q;
                    end else begin
                        state    <= WARN;
                        led_warn <= 1'b0;
                        warn_cnt <= '0;
                    end
                end

                VEND: begin
                    credit           <= remaining;
                    state            <= PAY;
                    chg.change_valid <= (remaining != '0);
                    chg.change_coin  <= pick_coin;
                end

                WARN: begin
                    if (cancel) begin
                        state            <= PAY;
                        led_warn         <= 1'b1;
                        warn_cnt         <= '0;
                        chg.change_valid <= (credit != '0);
                        chg.change_coin  <= pick_coin;
                    end else if (tick_1hz) begin
                        if (warn_cnt == WARN_W'(WARN_SECS - 1)) begin
                            state    <= COLLECT;
                            led_warn <= 1'b1;
                            busy     <= 1'b0;
                            warn_cnt <= '0;
                        end else begin
                            warn_cnt <= warn_cnt + 1'b1;
                        end
                    end
                end

                PAY: begin
                    if (chg.change_valid) begin
                        // Coin held stable until taken; one idle clk follows each transfer.
                        if (chg.change_ready) begin
                            credit           <= credit - coin_value(chg.change_coin);
                            chg.change_valid <= 1'b0;
                            chg.change_coin  <= COIN_NONE;
                        end
                    end else if (credit == '0) begin
                        state <= IDLE;
                        price <= '0;
                        busy  <= 1'b0;
                    end else begin
                        chg.change_valid <= 1'b1;
                        chg.change_coin  <= pick_coin;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vendor_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vendor_txn_ctrl
//   Scenario tasks for the vending sequencer plus a randomized purchase/refund
//   loop. Expected credit follows the coin acceptance rules in plain integer
//   arithmetic; expected change is the greedy 50/10/5 decomposition.
// ---------------------------------------------------------------------------
module tb_vendor_txn_ctrl;

    localparam logic [2:0] C5  = 3'b001;
    localparam logic [2:0] C10 = 3'b010;
    localparam logic [2:0] C50 = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       coin_valid = 1'b0;
    logic [2:0] coin = 3'b000;
    logic [3:0] sel = 4'b0000;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic [6:0] credit;
    logic [4:0] price;
    logic [3:0] dispense;
    logic       coin_reject;
    logic       led_warn;
    logic       busy;

    vendor_txn_ctrl_if chg();

    vendor_txn_ctrl #(
        .TIMEOUT_SECS (30),
        .WARN_SECS    (5),
        .MAX_CREDIT   (99)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .coin_valid  (coin_valid),
        .coin        (coin),
        .sel         (sel),
        .confirm     (confirm),
        .cancel      (cancel),
        .chg         (chg),
        .credit      (credit),
        .price       (price),
        .dispense    (dispense),
        .coin_reject (coin_reject),
        .led_warn    (led_warn),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int got_q[$];
    int exp_q[$];
    int hold_err;
    int disp_seen;
    bit timed_out;

    // ---------------- helpers (stimulus and model only) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [2:0] c);
        coin_valid = 1'b1;
        coin       = c;
        step();
        coin_valid = 1'b0;
        coin       = 3'b000;
    endtask

    task automatic do_confirm(input logic [3:0] s);
        sel     = s;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    function automatic int code2val(input logic [2:0] c);
        case (c)
            3'b001:  return 5;
            3'b010:  return 10;
            3'b100:  return 50;
            default: return -1;
        endcase
    endfunction

    // Greedy change list for an amount, largest coins first.
    task automatic build_exp(input int amt);
        int rest;
        exp_q.delete();
        rest = amt;
        while (rest >= 50) begin exp_q.push_back(50); rest -= 50; end
        while (rest >= 10) begin exp_q.push_back(10); rest -= 10; end
        while (rest >= 5)  begin exp_q.push_back(5);  rest -= 5;  end
    endtask

    function automatic bit seq_eq();
        if (got_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] != exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string seq_str(input bit use_got);
        string s;
        int    n;
        s = "[";
        n = use_got ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            s = {s, $sformatf(" %0d", use_got ? got_q[i] : exp_q[i])};
        return {s, " ]"};
    endfunction

    // Plays the hopper until the sequencer drops busy; records taken coins.
    task automatic collect(input bit rnd_ready);
        logic       pv;
        logic [2:0] pc;
        got_q.delete();
        hold_err  = 0;
        disp_seen = 0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            chg.change_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            pv = chg.change_valid;
            pc = chg.change_coin;
            if (pv && chg.change_ready) got_q.push_back(code2val(pc));
            step();
            if (pv && !chg.change_ready &&
                (chg.change_valid !== 1'b1 || chg.change_coin !== pc)) hold_err++;
            if (dispense !== 4'b0000) disp_seen++;
        end
        chg.change_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [22:0] obs;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        obs = {credit, price, dispense, coin_reject, chg.change_valid, chg.change_coin, led_warn, busy};
        n_vec++;
        if (obs !== {7'd0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            $display("FAIL reset_values: got %h want %h", obs, {7'd0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
            n_err++;
        end
    endtask

    task automatic test_purchase();
        put_coin(C10);
        put_coin(C10);
        n_vec++;
        if (credit !== 7'd20 || coin_reject !== 1'b0) begin
            $display("FAIL purchase_credit: credit %0d rej %b, want 20 0", credit, coin_reject);
            n_err++;
        end
        do_confirm(4'b0100);
        n_vec++;
        if (price !== 5'd15 || dispense !== 4'b0000 || busy !== 1'b1) begin
            $display("FAIL purchase_check: price %0d disp %b busy %b, want 15 0000 1", price, dispense, busy);
            n_err++;
        end
        step();
        n_vec++;
        if (dispense !== 4'b0100) begin
            $display("FAIL purchase_dispense: got %b want 0100", dispense);
            n_err++;
        end
        step();
        n_vec++;
        if (dispense !== 4'b0000 || chg.change_valid !== 1'b1 || chg.change_coin !== C5 || credit !== 7'd5) begin
            $display("FAIL purchase_first_change: disp %b v %b coin %b credit %0d, want 0000 1 001 5",
                     dispense, chg.change_valid, chg.change_coin, credit);
            n_err++;
        end
        collect(1'b0);
        build_exp(5);
        n_vec++;
        if (timed_out || !seq_eq() || credit !== 7'd0 || price !== 5'd0 || busy !== 1'b0) begin
            $display("FAIL purchase_payout: got %s credit %0d price %0d busy %b to %b, want %s 0 0 0 0",
                     seq_str(1'b1), credit, price, busy, timed_out, seq_str(1'b0));
            n_err++;
        end
    endtask

    task automatic test_overflow();
        put_coin(C50);
        put_coin(C50);
        n_vec++;
        if (coin_reject !== 1'b1 || credit !== 7'd50) begin
            $display("FAIL overflow_reject: rej %b credit %0d, want 1 50", coin_reject, credit);
            n_err++;
        end
        step();
        n_vec++;
        if (coin_reject !== 1'b0) begin
            $display("FAIL overflow_reject_width: rej %b want 0", coin_reject);
            n_err++;
        end
        do_confirm(4'b0001);
        step();
        n_vec++;
        if (dispense !== 4'b0001) begin
            $display("FAIL overflow_dispense: got %b want 0001", dispense);
            n_err++;
        end
        collect(1'b1);
        build_exp(45);
        n_vec++;
        if (timed_out || !seq_eq() || hold_err != 0 || credit !== 7'd0) begin
            $display("FAIL overflow_payout: got %s credit %0d hold %0d to %b, want %s 0 0 0",
                     seq_str(1'b1), credit, hold_err, timed_out, seq_str(1'b0));
            n_err++;
        end
    endtask

    task automatic test_warn();
        put_coin(C5);
        do_confirm(4'b1000);
        step();
        n_vec++;
        if (led_warn !== 1'b0 || dispense !== 4'b0000 || busy !== 1'b1) begin
            $display("FAIL warn_enter: led %b disp %b busy %b, want 0 0000 1", led_warn, dispense, busy);
            n_err++;
        end
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            step();
            n_vec++;
            if (led_warn !== 1'b0 || dispense !== 4'b0000) begin
                $display("FAIL warn_hold_%0d: led %b disp %b, want 0 0000", i, led_warn, dispense);
                n_err++;
            end
        end
        do_tick();
        n_vec++;
        if (led_warn !== 1'b1 || busy !== 1'b0 || credit !== 7'd5) begin
            $display("FAIL warn_exit: led %b busy %b credit %0d, want 1 0 5", led_warn, busy, credit);
            n_err++;
        end
        put_coin(C10);
        put_coin(C5);
        do_confirm(4'b1000);
        step();
        n_vec++;
        if (dispense !== 4'b1000) begin
            $display("FAIL warn_retry_dispense: got %b want 1000", dispense);
            n_err++;
        end
        collect(1'b0);
        build_exp(0);
        n_vec++;
        if (timed_out || !seq_eq() || credit !== 7'd0 || busy !== 1'b0) begin
            $display("FAIL warn_retry_change: got %s credit %0d to %b, want %s 0 0",
                     seq_str(1'b1), credit, timed_out, seq_str(1'b0));
            n_err++;
        end
    endtask

    task automatic test_hold();
        int hold;
        put_coin(C50);
        chg.change_ready = 1'b0;
        do_cancel();
        n_vec++;
        if (chg.change_valid !== 1'b1 || chg.change_coin !== C50) begin
            $display("FAIL hold_offer: v %b coin %b, want 1 100", chg.change_valid, chg.change_coin);
            n_err++;
        end
        hold = 0;
        repeat (10) begin
            step();
            if (chg.change_valid !== 1'b1 || chg.change_coin !== C50) hold++;
        end
        n_vec++;
        if (hold != 0 || credit !== 7'd50) begin
            $display("FAIL hold_stable: unstable clks %0d credit %0d, want 0 50", hold, credit);
            n_err++;
        end
        chg.change_ready = 1'b1;
        step();
        chg.change_ready = 1'b0;
        step();
        n_vec++;
        if (credit !== 7'd0 || chg.change_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL hold_done: credit %0d v %b busy %b, want 0 0 0", credit, chg.change_valid, busy);
            n_err++;
        end
    endtask

    task automatic test_priority();
        put_coin(C10);
        put_coin(C5);
        cancel     = 1'b1;
        confirm    = 1'b1;
        sel        = 4'b0001;
        coin_valid = 1'b1;
        coin       = C10;
        step();
        cancel     = 1'b0;
        confirm    = 1'b0;
        coin_valid = 1'b0;
        coin       = 3'b000;
        n_vec++;
        if (coin_reject !== 1'b1 || dispense !== 4'b0000 || busy !== 1'b1 || credit !== 7'd15 || price !== 5'd0) begin
            $display("FAIL priority_cancel: rej %b disp %b busy %b credit %0d price %0d, want 1 0000 1 15 0",
                     coin_reject, dispense, busy, credit, price);
            n_err++;
        end
        collect(1'b1);
        build_exp(15);
        n_vec++;
        if (timed_out || !seq_eq() || disp_seen != 0 || hold_err != 0 || credit !== 7'd0) begin
            $display("FAIL priority_refund: got %s disp %0d hold %0d credit %0d, want %s 0 0 0",
                     seq_str(1'b1), disp_seen, hold_err, credit, seq_str(1'b0));
            n_err++;
        end
    endtask

    task automatic test_timeout();
        put_coin(C10);
        repeat (29) begin
            do_tick();
            step();
        end
        n_vec++;
        if (busy !== 1'b0 || credit !== 7'd10 || chg.change_valid !== 1'b0) begin
            $display("FAIL timeout_early: busy %b credit %0d v %b, want 0 10 0", busy, credit, chg.change_valid);
            n_err++;
        end
        do_tick();
        n_vec++;
        if (busy !== 1'b1 || chg.change_valid !== 1'b1 || chg.change_coin !== C10) begin
            $display("FAIL timeout_fire: busy %b v %b coin %b, want 1 1 010", busy, chg.change_valid, chg.change_coin);
            n_err++;
        end
        collect(1'b1);
        build_exp(10);
        n_vec++;
        if (timed_out || !seq_eq() || credit !== 7'd0) begin
            $display("FAIL timeout_refund: got %s credit %0d, want %s 0", seq_str(1'b1), credit, seq_str(1'b0));
            n_err++;
        end
    endtask

    task automatic test_reset_in_pay();
        logic [22:0] obs;
        put_coin(C50);
        chg.change_ready = 1'b0;
        do_cancel();
        step();
        n_vec++;
        if (busy !== 1'b1 || chg.change_valid !== 1'b1) begin
            $display("FAIL rstpay_pre: busy %b v %b, want 1 1", busy, chg.change_valid);
            n_err++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs = {credit, price, dispense, coin_reject, chg.change_valid, chg.change_coin, led_warn, busy};
        n_vec++;
        if (obs !== {7'd0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            $display("FAIL rstpay_values: got %h want %h", obs, {7'd0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
            n_err++;
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || credit !== 7'd0 || chg.change_valid !== 1'b0) begin
            $display("FAIL rstpay_after: busy %b credit %0d v %b, want 0 0 0", busy, credit, chg.change_valid);
            n_err++;
        end
    endtask

    task automatic test_random();
        int          m_credit;
        int          ncoins;
        int          r;
        int          v;
        int          idx;
        int          p;
        logic [2:0]  c;
        logic [3:0]  s;
        bit          exp_rej;
        for (int t = 0; t < 30; t++) begin
            m_credit = 0;
            ncoins   = $urandom_range(1, 4);
            for (int k = 0; k < ncoins; k++) begin
                r = (k == 0) ? $urandom_range(0, 6) : $urandom_range(0, 7);
                if (r <= 2)      begin c = C5;     v = 5;  end
                else if (r <= 4) begin c = C10;    v = 10; end
                else if (r <= 6) begin c = C50;    v = 50; end
                else             begin c = 3'b011; v = 0;  end
                exp_rej = (v == 0) || (m_credit + v > 99);
                if (!exp_rej) m_credit += v;
                put_coin(c);
                n_vec++;
                if (coin_reject !== exp_rej || credit !== 7'(m_credit)) begin
                    $display("FAIL rnd_coin t%0d k%0d: rej %b credit %0d, want %b %0d",
                             t, k, coin_reject, credit, exp_rej, m_credit);
                    n_err++;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                do_cancel();
            end else begin
                idx = $urandom_range(0, 3);
                s   = 4'(1 << idx);
                p   = 5 * (idx + 1);
                do_confirm(s);
                step();
                if (m_credit >= p) begin
                    n_vec++;
                    if (dispense !== s || led_warn !== 1'b1) begin
                        $display("FAIL rnd_vend t%0d: disp %b led %b, want %b 1", t, dispense, led_warn, s);
                        n_err++;
                    end
                    m_credit -= p;
                end else begin
                    n_vec++;
                    if (dispense !== 4'b0000 || led_warn !== 1'b0) begin
                        $display("FAIL rnd_warn t%0d: disp %b led %b, want 0000 0", t, dispense, led_warn);
                        n_err++;
                    end
                    do_cancel();
                end
            end
            collect(1'b1);
            build_exp(m_credit);
            n_vec++;
            if (timed_out || !seq_eq() || hold_err != 0 || credit !== 7'd0 || led_warn !== 1'b1) begin
                $display("FAIL rnd_payout t%0d: got %s hold %0d credit %0d led %b to %b, want %s 0 0 1 0",
                         t, seq_str(1'b1), hold_err, credit, led_warn, timed_out, seq_str(1'b0));
                n_err++;
            end
        end
    endtask

    initial begin
        chg.change_ready = 1'b0;
        test_reset();
        test_purchase();
        test_overflow();
        test_warn();
        test_hold();
        test_priority();
        test_timeout();
        test_reset_in_pay();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
